dmac_apb_master: RTL
====================

# dmac_apb_master

APB initiator that turns a single-outstanding valid/ready request stream into APB transfers toward a DMAC register slave, and returns read data and error status on a valid/ready response stream. It sits between the DMA engine's control sequencer (or a CPU-side bridge) and the APB bus. It drives the psel/penable/paddr/pwrite/pwdata side that the DMAC configuration slave answers. It adds a stall timeout so that a slave holding pready low cannot hang the initiator.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports (clock and reset: one clock; reset is asynchronous and active-low, ports `clk` and `rst_n`):
- clk  in  1  clock, all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when both high at a rising edge
- req_addr_i  in  ADDR_W  transfer address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DATA_W  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when both high at a rising edge
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err_o  out  1  pslverr or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- psel_o, penable_o  out  1  APB select / enable
- paddr_o  out  ADDR_W  APB address
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_W  APB write data
- pready_i, pslverr_i  in  1  APB ready / slave error
- prdata_i  in  DATA_W  APB read data

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP. All outputs are registered.
- IDLE: req_ready_o=1. On req_valid_i&req_ready_o, capture addr/write/wdata into paddr_o/pwrite_o/pwdata_o and go to SETUP.
- SETUP: psel_o=1, penable_o=0. Clear the timeout counter. Next state is ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1: capture rdata (prdata_i for reads, 0 for writes) and err=pslverr_i, set timeout=0, go to RESP.
  - pready_i=0: counter+1.
  - TIMEOUT_CYCLES≠0, counter==TIMEOUT_CYCLES-1 and pready_i=0: abort with rdata=0, err=1, timeout=1, go to RESP.
  - pready_i=1 on the limit cycle: a normal completion wins.
- RESP: psel_o=penable_o=0, rsp_valid_o=1. Hold rsp_* stable until rsp_ready_i=1, then go to IDLE.
- Only one transfer is in flight. req_ready_o=0 in every state except IDLE.
- paddr_o/pwrite_o/pwdata_o stay constant from SETUP through ACCESS. They hold their last value otherwise.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps; it saturates at the limit.
- rsp_err_o = pslverr_i on a normal completion. rsp_rdata_o still carries prdata_i for reads with pslverr.

## Timing
- Reset values: state IDLE, and every output is 0, including req_ready_o. req_ready_o rises at the first rising edge with rst_n high.
- Request accepted at edge k:
  - cycle k+1: psel=1, penable=0
  - cycle k+2: penable=1
  - pready=1 sampled at the end of k+2 → cycle k+3: psel=penable=0, rsp_valid=1
  - rsp_ready=1 in k+3 → req_ready=1 in k+4
- Minimum throughput is 4 cycles per transfer. Each wait state adds 1 cycle.
- A timeout ends ACCESS after exactly TIMEOUT_CYCLES cycles. psel drops on the following cycle.
- rsp_ready_i=1 while rsp_valid_o=0 is ignored. req_valid_i outside IDLE is ignored; the request must be held by the source.
- Reset asserted mid-transfer, in any state: all outputs go to reset values immediately. The transfer is dropped and no response is produced.

## Test plan
- Reset: rst_n low 3 cycles → all outputs 0 during reset; req_ready_o=1 one edge after release; psel_o stays 0 with no request.
- Write 0x10C ← 0x1, slave pready=1 immediately → psel at k+1, penable at k+2, paddr=0x10C, pwdata=0x1, pwrite=1; rsp_valid at k+3 with rdata=0, err=0, timeout=0.
- Read 0x000, slave inserts 3 wait states, prdata=0x0001_2025 → ACCESS lasts 4 cycles, paddr stable throughout; rsp_rdata=0x00012025, err=0.
- Read 0x200 with pslverr=1, prdata=0xDEAD → rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEAD.
- TIMEOUT_CYCLES=16, pready held 0 → penable high exactly 16 cycles, then rsp_err=1, rsp_timeout=1, rdata=0. Second run with pready=1 on the 16th ACCESS cycle → normal completion, timeout=0.
- rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 with no new psel; then rst_n pulsed low mid-ACCESS → psel/penable/rsp_valid drop to 0 asynchronously and no response is produced after release.

Source files
------------

// File: rtl/dmac_apb_master.sv
// dmac_apb_master
// APB initiator for the DMAC register slave. Accepts one request at a time on
// a valid/ready request stream, runs a SETUP + ACCESS APB transfer, and returns
// read data and error status on a valid/ready response stream. A stall counter
// aborts an ACCESS phase that waits TIMEOUT_CYCLES cycles without pready.
//
// Handshake rule (both streams): a beat transfers on a rising clk edge where
// valid and ready are both high. The request source must hold req_* stable
// while req_valid_i is high and not yet accepted. rsp_* hold stable while
// rsp_valid_o is high and rsp_ready_i is low.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake; req_addr_i, req_write_i, req_wdata_i
//   rsp_valid_o/ready_i  response handshake; rsp_rdata_o, rsp_err_o, rsp_timeout_o
//   psel_o .. pwdata_o   APB request side
//   pready_i, pslverr_i, prdata_i  APB completion side
//   state_o              current FSM state (debug observation)
module dmac_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_write_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic              pslverr_i,
  input  logic [DATA_W-1:0] prdata_i,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter needs to hold 0..TIMEOUT_CYCLES; a disabled timeout still keeps a
  // 1-bit counter so the datapath stays uniform.
  localparam int        CW       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit        TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'((TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      paddr_o       <= '0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready_o is itself registered, so the first edge out of reset
          // only raises it; acceptance needs it already high.
          if (req_valid_i && req_ready_o) begin
            paddr_o     <= req_addr_i;
            pwrite_o    <= req_write_i;
            pwdata_o    <= req_wdata_i;
            psel_o      <= 1'b1;
            req_ready_o <= 1'b0;
            state       <= S_SETUP;
          end else begin
            req_ready_o <= 1'b1;
          end
        end

        S_SETUP: begin
          penable_o <= 1'b1;
          cnt       <= '0;
          state     <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready_i) begin
            // Normal completion, including on the limit cycle.
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            state         <= S_RESP;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_valid_o   <= 1'b1;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            state         <= S_RESP;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
